rank_sort_stream: RTL and testbench
===================================

// Module: rank_sort_stream
// PURPOSE
//   Parametrised N-entry, WIDTH-bit rank sorter with valid/ready on input and output vectors.
//   - Sorts ascending or descending, with signed or unsigned compare.
//   - Stable: equal keys keep their input order.
//   - Ranks one element per cycle using N parallel comparators, so area is O(N) comparators,
//     not O(N^2).
//   - Placed between a vector producer and consumer in the datapath; next generation of the
//     team's one-shot FSM sorter.
// PARAMETERS
//   N          8   number of elements per vector, N >= 2
//   WIDTH      16  bits per element, WIDTH >= 1
//   SIGNED_CMP 0   1 = two's-complement compare, 0 = unsigned compare
// PORTS
//   clk        in   1          single clock, rising edge
//   rst_n      in   1          asynchronous active-low reset
//   in_valid   in   1          data_in/descend valid
//   in_ready   out  1          block can accept a vector
//   descend    in   1          1 = largest first; sampled on accept
//   data_in    in   WIDTH x N  unpacked input vector [N]
//   out_valid  out  1          data_sorted valid
//   out_ready  in   1          consumer accepts data_sorted
//   data_sorted out WIDTH x N  unpacked sorted vector [N]
//   out_idx    out  IW x N     original index of each sorted element; SORT_IDX_EN only
//                              (IW = $clog2(N))
// BEHAVIOUR
//   - Reset (async assert, deasserted synchronously upstream):
//     state=IDLE, in_ready=1, out_valid=0, data_sorted all 0, out_idx all 0, idx counter=0.
//   - FSM states: IDLE -> RANK -> HOLD -> IDLE.
//   - IDLE:
//     - in_ready=1.
//     - On in_valid&in_ready: capture data_in into key[N] and latch descend.
//     - Clear idx, go to RANK.
//   - RANK:
//     - in_ready=0, out_valid=0.
//     - Each cycle computes rank r for element key[idx]:
//       r = #{j : key[j] precedes key[idx]} + #{j < idx : key[j] == key[idx]}.
//       "Precedes" means < for ascending, > for descending, per SIGNED_CMP.
//     - Write data_sorted[r] <= key[idx]; out_idx[r] <= idx.
//     - idx increments. After idx==N-1 is written, go to HOLD.
//     - data_sorted is partially overwritten during RANK; it is only valid when out_valid=1.
//   - HOLD:
//     - out_valid=1, in_ready=0.
//     - data_sorted/out_idx stay stable until out_valid&out_ready, then go to IDLE.
//   - Timing:
//     - Latency: out_valid rises exactly N rising edges after the accept edge.
//     - Throughput: one vector per N+2 cycles at minimum (accept, N rank cycles, 1 HOLD cycle
//       with out_ready=1).
//     - in_ready is a registered state decode. No combinational in->out path.
//   - Ranks form a permutation of 0..N-1 because ties are resolved by index, so no write
//     collisions occur.
//   - Boundary conditions:
//     - All-equal input: output equals input order; out_idx = 0..N-1.
//     - in_valid held high during RANK/HOLD: ignored; the vector is taken on the next IDLE cycle.
//     - out_ready held high before out_valid: no effect.
//     - Reset mid-RANK or mid-HOLD: immediate return to reset values; the partial result is
//       discarded.
//     - descend and data_in changing after accept: no effect on the result in flight.
// CONFIGURATION
//   - SORT_IDX_EN defined: out_idx port exists. Each entry holds the original position (IW
//     bits) of the element in the same data_sorted slot; reset 0; stable during HOLD.
//   - SORT_IDX_EN undefined: out_idx port and its registers are absent. The index of the
//     current element is still used internally for tie-breaking.
// STRUCTURE
//   - sort_pkg:
//     - typedef enum logic [1:0] {IDLE, RANK, HOLD} sort_state_t.
//     - function automatic int idx_w(int n) returning max(1, $clog2(n)).
//   - Sub-module sort_rank_unit #(N, WIDTH, SIGNED_CMP): purely combinational.
//     - Inputs: key[N], sel index, descend.
//     - Output: rank (IW bits), computed with N comparators plus a popcount.
//   - Top: FSM, idx counter, key/result registers, handshake.
// TESTING
//   1. N=8, W=16, ascending: in {5,3,9,1,7,2,8,4} -> out {1,2,3,4,5,7,8,9}; out_valid 8 edges
//      after accept; idx {3,5,1,7,0,4,6,2}.
//   2. Same data with descend=1 -> out {9,8,7,5,4,3,2,1}.
//   3. Stability: in {4,2,4,2,4,2,4,2} ascending -> out {2,2,2,2,4,4,4,4},
//      idx {1,3,5,7,0,2,4,6}.
//   4. SIGNED_CMP=1: in {-1,0,1,-128,...} -> -128 first; SIGNED_CMP=0 -> 0x00 first, 0xFF
//      after 0x80.
//   5. Backpressure: hold out_ready=0 for 20 cycles -> out_valid and data stable, in_ready=0;
//      a second vector presented meanwhile is accepted only on the cycle after the out
//      handshake.
//   6. rst_n pulsed low at RANK idx=3 -> all outputs 0, in_ready=1 next edge; a new vector then
//      sorts correctly.

Source files
------------

// File: rtl/rank_sort_stream_pkg.sv
// Shared types and helpers for the rank sorter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package rank_sort_stream_pkg;

   // Sorter control states: wait for a vector, rank one element per cycle, present the result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RANK = 2'd1,
      HOLD = 2'd2
   } sort_state_t;

   // Index width that is at least one bit, even for tiny N.
   function automatic int idx_w(input int n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rank_sort_stream_if.sv
// Vector handshake bundle between producer, rank sorter and consumer.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the input vector, out_valid/out_ready on the sorted vector.
// Ports: in_valid, in_ready, descend, data_in[N], out_valid, out_ready, data_sorted[N],
//        out_idx[N] (only when SORT_IDX_EN is defined).
interface rank_sort_stream_if
   import rank_sort_stream_pkg::*;
#(
   parameter int N     = 8,
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic             descend;
   logic [WIDTH-1:0] data_in [N];
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] data_sorted [N];
`ifdef SORT_IDX_EN
   localparam int IW = idx_w(N);
   logic [IW-1:0]    out_idx [N];
`endif

   // Producer/consumer side (drives inputs, reads results).
   modport master (
      output in_valid, descend, data_in, out_ready,
      input  in_ready, out_valid, data_sorted
`ifdef SORT_IDX_EN
      , input out_idx
`endif
   );

   // Sorter side.
   modport slave (
      input  in_valid, descend, data_in, out_ready,
      output in_ready, out_valid, data_sorted
`ifdef SORT_IDX_EN
      , output out_idx
`endif
   );
endinterface

// File: rtl/rank_sort_stream_rank_unit.sv
// Computes the final sorted position of key[sel] within key[].
// Latency: purely combinational, 0 cycles.
// Backpressure: none; evaluated every cycle.
// Ports: key[N] vector, sel element index, descend order, rank output (IW bits).
module rank_sort_stream_rank_unit
   import rank_sort_stream_pkg::*;
#(
   parameter  int N          = 8,
   parameter  int WIDTH      = 16,
   parameter  int SIGNED_CMP = 0,
   localparam int IW         = idx_w(N)
) (
   input  logic [WIDTH-1:0] key [N],
   input  logic [IW-1:0]    sel,
   input  logic             descend,
   output logic [IW-1:0]    rank
);

   // True when a is strictly smaller than b under the configured number format.
   function automatic logic less(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      if (SIGNED_CMP != 0) return $signed(a) < $signed(b);
      else                 return a < b;
   endfunction

   logic [WIDTH-1:0] cur;
   logic [N-1:0]     hit;
   logic [IW-1:0]    cnt;

   assign cur = key[sel];

   // One comparator per slot: key[j] lands ahead of cur if it strictly precedes it, or if it
   // is equal and came earlier in the input. The tie rule makes ranks a permutation.
   always_comb begin
      hit = '0;
      cnt = '0;
      for (int j = 0; j < N; j++) begin
         hit[j] = (descend ? less(cur, key[j]) : less(key[j], cur)) |
                  ((IW'(j) < sel) & (key[j] == cur));
         cnt    = cnt + IW'(hit[j]);
      end
   end

   assign rank = cnt;

endmodule

// File: rtl/rank_sort_stream.sv
// Stable N-entry rank sorter: captures a vector, ranks one element per cycle, presents the result.
// Latency: out_valid rises N clock edges after the accepting edge; N+2 cycles per vector minimum.
// Backpressure: in_ready only in IDLE; result held stable in HOLD until out_ready.
// Ports: clk, rst_n (async active-low), bus (rank_sort_stream_if.slave).
// Optional: define SORT_IDX_EN to add bus.out_idx (original index of each sorted element).
module rank_sort_stream
   import rank_sort_stream_pkg::*;
#(
   parameter int N          = 8,
   parameter int WIDTH      = 16,
   parameter int SIGNED_CMP = 0
) (
   input logic                clk,
   input logic                rst_n,
   rank_sort_stream_if.slave  bus
);

   localparam int IW = idx_w(N);

   sort_state_t      state;
   sort_state_t      state_nxt;
   logic [WIDTH-1:0] key [N];
   logic [WIDTH-1:0] sorted_q [N];
   logic             desc_q;
   logic [IW-1:0]    idx;
   logic [IW-1:0]    rank;
   logic             accept;
   logic             last;
`ifdef SORT_IDX_EN
   logic [IW-1:0]    idx_q [N];
`endif

   assign accept = bus.in_valid & (state == IDLE);
   assign last   = (idx == IW'(N - 1));

   rank_sort_stream_rank_unit #(
      .N          (N),
      .WIDTH      (WIDTH),
      .SIGNED_CMP (SIGNED_CMP)
   ) u_rank (
      .key     (key),
      .sel     (idx),
      .descend (desc_q),
      .rank    (rank)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = RANK;
         RANK:    if (last) state_nxt = HOLD;
         HOLD:    if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs are pure decodes of the state register.
   always_comb begin
      bus.in_ready  = (state == IDLE);
      bus.out_valid = (state == HOLD);
   end

   // Datapath: key capture, idx counter and scatter of each ranked element into its slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         desc_q <= 1'b0;
         idx    <= '0;
         for (int i = 0; i < N; i++) begin
            key[i]      <= '0;
            sorted_q[i] <= '0;
`ifdef SORT_IDX_EN
            idx_q[i]    <= '0;
`endif
         end
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  desc_q <= bus.descend;
                  idx    <= '0;
                  for (int i = 0; i < N; i++) key[i] <= bus.data_in[i];
               end
            end
            RANK: begin
               sorted_q[rank] <= key[idx];
`ifdef SORT_IDX_EN
               idx_q[rank]    <= idx;
`endif
               idx            <= idx + IW'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.data_sorted = sorted_q;
`ifdef SORT_IDX_EN
   assign bus.out_idx     = idx_q;
`endif

endmodule

// File: tb/tb_rank_sort_stream.sv
// Bench for rank_sort_stream: main unsigned N=8/W=16 instance plus a signed N=4/W=8 instance.
// Latency: checks out_valid arrives exactly N edges after accept.
// Backpressure: stalls out_ready and presents a second vector while the result is held.
module tb_rank_sort_stream;
   import rank_sort_stream_pkg::*;

   localparam int N = 8;
   localparam int W = 16;

   typedef logic [N-1:0][W-1:0] pvec_t;
   typedef logic [N-1:0][2:0]   pidx_t;

   logic  clk   = 1'b0;
   logic  rst_n = 1'b0;
   int    cyc   = 0;
   int    acc_cyc = 0;
   int    n_cmp = 0;
   int    n_err = 0;

   pvec_t sb_d [$];
   pidx_t sb_i [$];

   rank_sort_stream_if #(.N(N), .WIDTH(W)) bif ();
   rank_sort_stream_if #(.N(4), .WIDTH(8)) sif ();

   rank_sort_stream #(.N(N), .WIDTH(W), .SIGNED_CMP(0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif.slave)
   );

   rank_sort_stream #(.N(4), .WIDTH(8), .SIGNED_CMP(1)) dut_s (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sif.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic pvec_t mk8(input int a0, input int a1, input int a2, input int a3,
                                 input int a4, input int a5, input int a6, input int a7);
      pvec_t v;
      v[0] = W'(a0); v[1] = W'(a1); v[2] = W'(a2); v[3] = W'(a3);
      v[4] = W'(a4); v[5] = W'(a5); v[6] = W'(a6); v[7] = W'(a7);
      return v;
   endfunction

   function automatic pidx_t mki(input int a0, input int a1, input int a2, input int a3,
                                 input int a4, input int a5, input int a6, input int a7);
      pidx_t v;
      v[0] = 3'(a0); v[1] = 3'(a1); v[2] = 3'(a2); v[3] = 3'(a3);
      v[4] = 3'(a4); v[5] = 3'(a5); v[6] = 3'(a6); v[7] = 3'(a7);
      return v;
   endfunction

   // Reference: stable insertion sort on (value, original index) pairs, unsigned compare.
   function automatic void model(input pvec_t v, input logic desc, output pvec_t od, output pidx_t oi);
      logic [W-1:0] kv;
      logic [2:0]   ki;
      int           j;
      bit           done;
      od = v;
      for (int i = 0; i < N; i++) oi[i] = 3'(i);
      for (int i = 1; i < N; i++) begin
         kv   = od[i];
         ki   = oi[i];
         j    = i - 1;
         done = 1'b0;
         while (!done) begin
            if (j < 0) done = 1'b1;
            else if (desc ? (kv > od[j]) : (kv < od[j])) begin
               od[j+1] = od[j];
               oi[j+1] = oi[j];
               j--;
            end else done = 1'b1;
         end
         od[j+1] = kv;
         oi[j+1] = ki;
      end
   endfunction

   task automatic send(input pvec_t v, input logic desc);
      int    t;
      pvec_t ed;
      pidx_t ei;
      @(negedge clk);
      bif.in_valid = 1'b1;
      bif.descend  = desc;
      for (int i = 0; i < N; i++) bif.data_in[i] = v[i];
      t = 0;
      while (!bif.in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!bif.in_ready) begin
         chk("accept_timeout", 32'd0, 32'd1);
         bif.in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      model(v, desc, ed, ei);
      sb_d.push_back(ed);
      sb_i.push_back(ei);
      // Scramble inputs right after accept: the result in flight must not change.
      bif.in_valid = 1'b0;
      bif.descend  = ~desc;
      for (int i = 0; i < N; i++) bif.data_in[i] = ~v[i];
   endtask

   task automatic wait_out(input bit check_lat);
      int t;
      t = 0;
      while (!bif.out_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!bif.out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
      else if (check_lat) chk("latency", 32'(cyc - acc_cyc), 32'(N));
   endtask

   task automatic take_out();
      pvec_t ed;
      pidx_t ei;
      if (sb_d.size() == 0) begin
         chk("sb_underflow", 32'd0, 32'd1);
         return;
      end
      ed = sb_d.pop_front();
      ei = sb_i.pop_front();
      for (int i = 0; i < N; i++) begin
         chk("data_sorted", 32'(bif.data_sorted[i]), 32'(ed[i]));
`ifdef SORT_IDX_EN
         chk("out_idx", 32'(bif.out_idx[i]), 32'(ei[i]));
`endif
      end
      bif.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bif.out_ready = 1'b0;
      chk("out_valid_drop", 32'(bif.out_valid), 32'd0);
   endtask

   task automatic chk_const(input string tag, input pvec_t ed, input pidx_t ei);
      for (int i = 0; i < N; i++) begin
         chk(tag, 32'(bif.data_sorted[i]), 32'(ed[i]));
`ifdef SORT_IDX_EN
         chk({tag, "_idx"}, 32'(bif.out_idx[i]), 32'(ei[i]));
`endif
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      pvec_t v, v6, ed;
      pidx_t ei;
      logic  d;
      int    t;

      bif.in_valid  = 1'b0;
      bif.descend   = 1'b0;
      bif.out_ready = 1'b0;
      for (int i = 0; i < N; i++) bif.data_in[i] = '0;
      sif.in_valid  = 1'b0;
      sif.descend   = 1'b0;
      sif.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) sif.data_in[i] = '0;

      // Reset state
      #12;
      chk("rst_in_ready", 32'(bif.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bif.out_valid), 32'd0);
      for (int i = 0; i < N; i++) chk("rst_data", 32'(bif.data_sorted[i]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: ascending
      send(mk8(5, 3, 9, 1, 7, 2, 8, 4), 1'b0);
      wait_out(1'b1);
      take_out();
      chk_const("t1_asc", mk8(1, 2, 3, 4, 5, 7, 8, 9), mki(3, 5, 1, 7, 0, 4, 6, 2));

      // 2: descending, with out_ready already high during RANK
      bif.out_ready = 1'b1;
      send(mk8(5, 3, 9, 1, 7, 2, 8, 4), 1'b1);
      bif.out_ready = 1'b1;
      wait_out(1'b1);
      take_out();
      chk_const("t2_desc", mk8(9, 8, 7, 5, 4, 3, 2, 1), mki(2, 6, 4, 0, 7, 1, 5, 3));

      // 3: stability with ties
      send(mk8(4, 2, 4, 2, 4, 2, 4, 2), 1'b0);
      wait_out(1'b1);
      take_out();
      chk_const("t3_stable", mk8(2, 2, 2, 2, 4, 4, 4, 4), mki(1, 3, 5, 7, 0, 2, 4, 6));

      // All-equal input keeps input order
      send(mk8(7, 7, 7, 7, 7, 7, 7, 7), 1'b1);
      wait_out(1'b1);
      take_out();
      chk_const("all_equal", mk8(7, 7, 7, 7, 7, 7, 7, 7), mki(0, 1, 2, 3, 4, 5, 6, 7));

      // 4a: unsigned compare puts 0x00 first and 0xFF after 0x80
      send(mk8('hFF, 0, 1, 'h80, 'hFF, 0, 1, 'h80), 1'b0);
      wait_out(1'b1);
      take_out();
      chk_const("t4_unsigned", mk8(0, 0, 1, 1, 'h80, 'h80, 'hFF, 'hFF), mki(1, 5, 2, 6, 3, 7, 0, 4));

      // 4b: signed compare on the 8-bit instance: -128 first
      @(negedge clk);
      sif.in_valid   = 1'b1;
      sif.data_in[0] = 8'hFF;
      sif.data_in[1] = 8'h00;
      sif.data_in[2] = 8'h01;
      sif.data_in[3] = 8'h80;
      chk("s_in_ready", 32'(sif.in_ready), 32'd1);
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      sif.in_valid = 1'b0;
      t = 0;
      while (!sif.out_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("s_latency", 32'(cyc - acc_cyc), 32'd4);
      chk("s_data0", 32'(sif.data_sorted[0]), 32'h80);
      chk("s_data1", 32'(sif.data_sorted[1]), 32'hFF);
      chk("s_data2", 32'(sif.data_sorted[2]), 32'h00);
      chk("s_data3", 32'(sif.data_sorted[3]), 32'h01);
`ifdef SORT_IDX_EN
      chk("s_idx0", 32'(sif.out_idx[0]), 32'd3);
      chk("s_idx3", 32'(sif.out_idx[3]), 32'd2);
`endif
      sif.out_ready = 1'b1;
      @(posedge clk);
      #1;
      sif.out_ready = 1'b0;
      chk("s_out_valid_drop", 32'(sif.out_valid), 32'd0);

      // 5: backpressure with a second vector waiting
      send(mk8(10, 60, 30, 20, 50, 40, 80, 70), 1'b0);
      wait_out(1'b1);
      v6 = mk8(3, 1, 2, 0, 7, 5, 6, 4);
      bif.in_valid = 1'b1;
      bif.descend  = 1'b1;
      for (int i = 0; i < N; i++) bif.data_in[i] = v6[i];
      for (int c = 0; c < 20; c++) begin
         chk("bp_out_valid", 32'(bif.out_valid), 32'd1);
         chk("bp_in_ready", 32'(bif.in_ready), 32'd0);
         chk("bp_data0", 32'(bif.data_sorted[0]), 32'd10);
         chk("bp_data7", 32'(bif.data_sorted[7]), 32'd80);
         @(negedge clk);
      end
      take_out();
      chk("bp_idle_in_ready", 32'(bif.in_ready), 32'd1);
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      model(v6, 1'b1, ed, ei);
      sb_d.push_back(ed);
      sb_i.push_back(ei);
      bif.in_valid = 1'b0;
      chk("bp_second_taken", 32'(bif.in_ready), 32'd0);
      wait_out(1'b1);
      take_out();

      // 6: reset in the middle of RANK (idx == 3)
      send(mk8(9, 9, 9, 1, 1, 1, 5, 5), 1'b0);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      void'(sb_d.pop_back());
      void'(sb_i.pop_back());
      chk("mid_rst_in_ready", 32'(bif.in_ready), 32'd1);
      chk("mid_rst_out_valid", 32'(bif.out_valid), 32'd0);
      for (int i = 0; i < N; i++) begin
         chk("mid_rst_data", 32'(bif.data_sorted[i]), 32'd0);
`ifdef SORT_IDX_EN
         chk("mid_rst_idx", 32'(bif.out_idx[i]), 32'd0);
`endif
      end
      @(negedge clk);
      rst_n = 1'b1;
      send(mk8(12, 3, 44, 3, 0, 65535, 7, 12), 1'b0);
      wait_out(1'b1);
      take_out();

      // Random vectors with many ties and random order
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < N; i++) v[i] = W'($urandom_range(0, 7));
         d = 1'($urandom_range(0, 1));
         send(v, d);
         wait_out(1'b1);
         take_out();
      end

      chk("sb_empty", 32'(sb_d.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
